// File: rtl/alu_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the shared ALU.
// slave is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if;
  logic        req0, req1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1;
  logic        done0, done1;
  logic [31:0] result;
  logic        z_flag;
  logic        err;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic        alu_enable;
  logic [31:0] alu_c;
  logic        alu_z;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, alu_c, alu_z,
    output gnt0, gnt1, done0, done1, result, z_flag, err,
           alu_a, alu_b, alu_control, alu_enable
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, alu_c, alu_z,
    input  gnt0, gnt1, done0, done1, result, z_flag, err,
           alu_a, alu_b, alu_control, alu_enable
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter #(
  parameter int unsigned ALU_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]  gnt_cnt0,
  output logic [15:0]  gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE, DONE} state_t;

  localparam logic [3:0] LAST_COUNT = 4'(ALU_LATENCY - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic        last_reg;
  logic [31:0] alu_a_reg, alu_b_reg, result_reg;
  logic [3:0]  alu_control_reg;
  logic        z_reg, err_reg;

  logic        grant_any, grant_id, op_valid;
  logic [3:0]  op_sel;
  logic [31:0] a_sel, b_sel;
  logic [1:0]  gnt_vec;

  // Grant is combinational in IDLE so the operands latch on the same edge.
  always_comb begin : arbitrate
    grant_any = (state_reg == IDLE) && !rst && (bus.req0 || bus.req1);
    grant_id  = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;
    op_sel    = grant_id ? bus.op1 : bus.op0;
    a_sel     = grant_id ? bus.a1  : bus.a0;
    b_sel     = grant_id ? bus.b1  : bus.b0;
    op_valid  = (op_sel != 4'd0) && (op_sel <= 4'd9);
  end

  always_ff @(posedge clk or posedge rst) begin : state_register
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin : next_state
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = op_valid ? RUN : DONE;
      RUN:     if (cnt_reg == LAST_COUNT) state_next = CAPTURE;
      CAPTURE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin : outputs
    gnt_vec        = {grant_any & grant_id, grant_any & ~grant_id};
    bus.done0      = (state_reg == DONE) && !last_reg;
    bus.done1      = (state_reg == DONE) && last_reg;
    bus.alu_enable = (state_reg == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin : datapath
    if (rst) begin
      cnt_reg         <= '0;
      last_reg        <= 1'b1;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_control_reg <= '0;
      result_reg      <= '0;
      z_reg           <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      if (grant_any) begin
        last_reg        <= grant_id;
        alu_a_reg       <= a_sel;
        alu_b_reg       <= b_sel;
        alu_control_reg <= op_sel;
        cnt_reg         <= '0;
        // Illegal opcodes skip the ALU and report straight from DONE.
        if (!op_valid) begin
          result_reg <= '0;
          z_reg      <= 1'b0;
          err_reg    <= 1'b1;
        end
      end
      if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + 4'd1;
      end
      if (state_reg == CAPTURE) begin
        result_reg <= bus.alu_c;
        z_reg      <= bus.alu_z;
        err_reg    <= 1'b0;
      end
    end
  end

  assign bus.gnt0        = gnt_vec[0];
  assign bus.gnt1        = gnt_vec[1];
  assign bus.alu_a       = alu_a_reg;
  assign bus.alu_b       = alu_b_reg;
  assign bus.alu_control = alu_control_reg;
  assign bus.result      = result_reg;
  assign bus.z_flag      = z_reg;
  assign bus.err         = err_reg;

`ifdef ALU_ARB_STATS_EN
  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (gnt_vec[gi] && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign gnt_cnt0 = g_stats[0].cnt_reg;
  assign gnt_cnt1 = g_stats[1].cnt_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expectations queued at request time,
// popped and compared whenever a done pulse appears.
module tb_alu_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    bit          id;
    logic [31:0] res;
    bit          z;
    bit          err;
  } exp_t;

  exp_t sb[$];

  alu_arbiter_if bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  alu_arbiter #(.ALU_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return {31'b0, $signed(a) < $signed(b)};
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU; its zero flag is high for a non-zero result.
  assign bus.alu_c = alu_fn(bus.alu_control, bus.alu_a, bus.alu_b);
  assign bus.alu_z = (bus.alu_c != 32'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.gnt0 || bus.gnt1) check("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);
      if (bus.done0 || bus.done1) begin
        check("done_exclusive", 32'(bus.done0 & bus.done1), 32'd0);
        check("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("done%0d result=%0h z=%0b err=%0b exp_result=%0h", bus.done1, bus.result, bus.z_flag, bus.err, e.res);
          check("done_id", 32'(bus.done1), 32'(e.id));
          check("result", bus.result, e.res);
          check("err", 32'(bus.err), 32'(e.err));
          if (!e.err) check("z_flag", 32'(bus.z_flag), 32'(e.z));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic drive_req(input bit id, input bit val, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req1 = val; bus.op1 = op; bus.a1 = a; bus.b1 = b;
    end else begin
      bus.req0 = val; bus.op0 = op; bus.a0 = a; bus.b0 = b;
    end
  endtask

  task automatic run_op(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input bit exp_z);
    bit valid;
    bit got;
    int g_cyc, d_cyc, en_cnt, first_en;
    valid    = (op >= 4'd1) && (op <= 4'd9);
    en_cnt   = 0;
    first_en = -1;
    @(posedge clk); #1;
    drive_req(id, 1'b1, op, a, b);
    sb.push_back('{id: id, res: (valid ? exp_res : 32'd0), z: exp_z, err: !valid});
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? bus.gnt1 : bus.gnt0;
    end
    check("gnt_seen", 32'(got), 32'd1);
    g_cyc = cyc;
    @(posedge clk); #1;
    drive_req(id, 1'b0, op, a, b);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.alu_enable) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc - g_cyc;
        check("alu_a_stable", bus.alu_a, a);
        check("alu_ctl_stable", 32'(bus.alu_control), 32'(op));
      end
      got = id ? bus.done1 : bus.done0;
    end
    check("done_seen", 32'(got), 32'd1);
    d_cyc = cyc;
    check("gnt_to_done", 32'(d_cyc - g_cyc), valid ? 32'(LAT + 2) : 32'd1);
    check("enable_cycles", 32'(en_cnt), valid ? 32'(LAT) : 32'd0);
    if (valid) check("first_enable", 32'(first_en), 32'd1);
    @(negedge clk);
    check("result_hold", bus.result, valid ? exp_res : 32'd0);
  endtask

  initial begin
    int g_cyc, d_cyc, done_cnt;
    bit got;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    bit          rid;

    bus.req0 = 0; bus.req1 = 0;
    bus.op0 = 0; bus.op1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    do_reset();

    @(negedge clk);
    check("rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("rst_done0", 32'(bus.done0), 32'd0);
    check("rst_enable", 32'(bus.alu_enable), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_ctl", 32'(bus.alu_control), 32'd0);

    // Both requesters high straight out of reset: req0 first, then req1.
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 4'd1, 32'd10, 32'd3);
    drive_req(1'b1, 1'b1, 4'd2, 32'd10, 32'd3);
    sb.push_back('{id: 1'b0, res: 32'd13, z: 1'b1, err: 1'b0});
    sb.push_back('{id: 1'b1, res: 32'd7, z: 1'b1, err: 1'b0});
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.gnt0 | bus.gnt1;
    end
    check("rr_first_gnt0", 32'(bus.gnt0), 32'd1);
    g_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.done0;
    end
    check("rr_done0_seen", 32'(got), 32'd1);
    d_cyc = cyc;
    check("rr_done0_latency", 32'(d_cyc - g_cyc), 32'(LAT + 2));
    @(negedge clk);
    check("rr_gnt1_next_idle", 32'(bus.gnt1), 32'd1);
    g_cyc = cyc;
    @(posedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.done1;
    end
    check("rr_done1_seen", 32'(got), 32'd1);
    check("rr_done1_latency", 32'(cyc - g_cyc), 32'(LAT + 2));

    // Directed single operations.
    run_op(1'b0, 4'd1, 32'd5, 32'd7, 32'd12, 1'b1);
    run_op(1'b1, 4'd2, 32'd9, 32'd9, 32'd0, 1'b0);
    run_op(1'b1, 4'd2, 32'd9, 32'd4, 32'd5, 1'b1);
    run_op(1'b0, 4'd12, 32'd3, 32'd4, 32'd0, 1'b0);
    run_op(1'b1, 4'd0, 32'd3, 32'd4, 32'd0, 1'b0);

    // Reset in the second RUN cycle: enable drops at once, no done follows.
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 4'd1, 32'd1, 32'd2);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.gnt0;
    end
    check("rstrun_gnt0", 32'(got), 32'd1);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    check("rstrun_enable_before", 32'(bus.alu_enable), 32'd1);
    rst = 1'b1;
    #1;
    check("rstrun_enable_drop", 32'(bus.alu_enable), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) done_cnt++;
    end
    check("rstrun_no_done", 32'(done_cnt), 32'd0);
    run_op(1'b0, 4'd3, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b1);

    // Random mix including illegal opcodes.
    for (int i = 0; i < 8; i++) begin
      rid = 1'($urandom_range(0, 1));
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      run_op(rid, rop, ra, rb, alu_fn(rop, ra, rb), alu_fn(rop, ra, rb) != 32'd0);
    end

`ifdef ALU_ARB_STATS_EN
    do_reset();
    run_op(1'b0, 4'd1, 32'd1, 32'd1, 32'd2, 1'b1);
    run_op(1'b1, 4'd4, 32'd1, 32'd2, 32'd3, 1'b1);
    run_op(1'b0, 4'd12, 32'd1, 32'd1, 32'd0, 1'b0);
    run_op(1'b0, 4'd5, 32'd6, 32'd6, 32'd0, 1'b0);
    check("gnt_cnt0", 32'(gnt_cnt0), 32'd3);
    check("gnt_cnt1", 32'(gnt_cnt1), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
